// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: receive-side word handshake between a UART receiver and
// its consumer.
//
//   data_out    - received word, LSB is the first bit on the line
//   data_valid  - data_out and the error flags hold a word not yet accepted
//   data_ready  - consumer accepts the held word when high with data_valid
//   parity_err  - parity mismatch in the held word
//   frame_err   - a stop bit of the held word was sampled low
//   overrun_err - one-cycle pulse: a completed frame was discarded
//
// master: the receiver (drives word and flags); slave: the consumer.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output overrun_err,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a one-word output register.
//
// Ports:
//   clk     - system clock, all logic on the rising edge
//   rst_n   - synchronous active-low reset
//   rx      - asynchronous serial input, idle high
//   busy    - high whenever the receive FSM is not idle
//   out_if  - word handshake (uart_rx_cfg_if.master): data_out, data_valid,
//             data_ready, parity_err, frame_err, overrun_err
//
// Bits are sampled once per bit period by a down-counter reloaded with
// CPB-1; the start bit is qualified half a bit period after the falling
// edge so that every later sample lands near the middle of its bit.
module uart_rx_cfg #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    output logic            busy,
    uart_rx_cfg_if.master   out_if
);

    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int IW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_FULL  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CPB / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; resets to the idle line level so reset never
    // looks like a start bit.
    // ------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       rxs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rxs = sync_reg[1];

    // ------------------------------------------------------------------
    // Receive FSM and bit timing
    // ------------------------------------------------------------------
    state_t                 state_reg,    state_next;
    logic [CW-1:0]          cnt_reg,      cnt_next;
    logic [IW-1:0]          bit_idx_reg,  bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg,    shift_next;
    logic                   par_bit_reg,  par_bit_next;
    logic                   stop_idx_reg, stop_idx_next;
    logic                   ferr_acc_reg, ferr_acc_next;
    logic                   done_reg,     done_next;
    logic                   data_sample;
    logic                   tick;

    assign tick = (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            par_bit_reg  <= 1'b0;
            stop_idx_reg <= 1'b0;
            ferr_acc_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            par_bit_reg  <= par_bit_next;
            stop_idx_reg <= stop_idx_next;
            ferr_acc_reg <= ferr_acc_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        par_bit_next  = par_bit_reg;
        stop_idx_next = stop_idx_reg;
        ferr_acc_next = ferr_acc_reg;
        done_next     = 1'b0;
        data_sample   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!rxs) begin
                    state_next = ST_START;
                    cnt_next   = CNT_HALF;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (rxs) begin
                        // Line went back high: a glitch, not a start bit.
                        state_next = ST_IDLE;
                    end else begin
                        state_next    = ST_DATA;
                        bit_idx_next  = '0;
                        cnt_next      = CNT_FULL;
                        ferr_acc_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            ST_DATA: begin
                if (tick) begin
                    data_sample = 1'b1;
                    cnt_next    = CNT_FULL;
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next    = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        stop_idx_next = 1'b0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    par_bit_next  = rxs;
                    cnt_next      = CNT_FULL;
                    state_next    = ST_STOP;
                    stop_idx_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            ST_STOP: begin
                if (tick) begin
                    cnt_next      = CNT_FULL;
                    ferr_acc_next = ferr_acc_reg | ~rxs;
                    if (stop_idx_reg == STOP_LAST) begin
                        // Frame complete; a low line here is a break,
                        // which must end before another start is honoured.
                        done_next  = 1'b1;
                        state_next = rxs ? ST_IDLE : ST_BREAK;
                    end else begin
                        stop_idx_next = stop_idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            ST_BREAK: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Each data sample lands in the bit selected by the current index.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
        assign shift_next[gi] = (data_sample && (bit_idx_reg == IW'(gi)))
                              ? rxs : shift_reg[gi];
    end

    assign busy = (state_reg != ST_IDLE);

    // ------------------------------------------------------------------
    // Output word register. done_reg marks the cycle after the final stop
    // sample; shift_reg and par_bit_reg are still stable then because the
    // next frame cannot reach its first data sample that soon.
    // ------------------------------------------------------------------
    logic                 parity_calc;
    logic [DATA_BITS-1:0] data_out_reg;
    logic                 data_valid_reg;
    logic                 parity_err_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;

    assign parity_calc = (PARITY != 0) && (((^shift_reg) ^ par_bit_reg) != ODD_PAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (done_reg) begin
                if (!data_valid_reg || out_if.data_ready) begin
                    data_out_reg   <= shift_reg;
                    parity_err_reg <= parity_calc;
                    frame_err_reg  <= ferr_acc_reg;
                    data_valid_reg <= 1'b1;
                end else begin
                    // Consumer still holds the previous word: drop this one.
                    overrun_reg <= 1'b1;
                end
            end else if (data_valid_reg && out_if.data_ready) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    assign out_if.data_out    = data_out_reg;
    assign out_if.data_valid  = data_valid_reg;
    assign out_if.parity_err  = parity_err_reg;
    assign out_if.frame_err   = frame_err_reg;
    assign out_if.overrun_err = overrun_reg;

endmodule
